// File: rtl/operand_loader_pkg.sv
// Shared defaults, FSM state type and slot indices for the operand loader.
`default_nettype none
package operand_loader_pkg;
  localparam int DEF_WIDTH   = 4;
  localparam int DEF_NUM_OPS = 4;

  localparam int SLOT0 = 0;
  localparam int SLOT1 = 1;
  localparam int SLOT2 = 2;
  localparam int SLOT3 = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    OFFER   = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/operand_loader_if.sv
// Downstream valid/ready channel carrying the complete operand set.
`default_nettype none
interface operand_loader_if
  import operand_loader_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS
) ();
  logic [NUM_OPS*WIDTH-1:0] op_out;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output op_out, output out_valid, input out_ready);
  modport slave  (input op_out, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/operand_loader_strobe_debounce.sv
// Per-strobe synchroniser and debouncer with a one-cycle rising-edge flag.
`default_nettype none
module strobe_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic raw,
  output logic      rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   stable;
  logic                   sync_lvl;
  logic                   differ;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_lvl != stable);
  // High in the cycle before stable flips 0->1, so the capturing edge is the flip edge.
  assign rise     = differ && sync_lvl && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (differ) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_lvl;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/operand_loader.sv
// Captures debounced switch operands into slots and offers the full set downstream.
`default_nettype none
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int NUM_OPS         = DEF_NUM_OPS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               ena,
  input  wire logic               clear,
  input  wire logic [WIDTH-1:0]   data_in,
  input  wire logic [NUM_OPS-1:0] strobe_in,
  output logic      [NUM_OPS-1:0] op_loaded,
  output logic      [NUM_OPS-1:0] load_pulse,
  output logic                    overrun,
  operand_loader_if.master        bus
);
  logic [WIDTH-1:0]         data_sync [SYNC_STAGES];
  logic [NUM_OPS-1:0]       rise;
  logic [NUM_OPS*WIDTH-1:0] op_reg;
  logic                     valid_reg;
  state_t                   state;

  assign bus.op_out    = op_reg;
  assign bus.out_valid = valid_reg;

  generate
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_strobe
      strobe_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (strobe_in[i]),
        .rise (rise[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) data_sync[s] <= '0;
    end else begin
      data_sync[0] <= data_in;
      for (int s = 1; s < SYNC_STAGES; s++) data_sync[s] <= data_sync[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      op_reg     <= '0;
      op_loaded  <= '0;
      load_pulse <= '0;
      overrun    <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (clear) begin
      state      <= COLLECT;
      op_reg     <= '0;
      op_loaded  <= '0;
      load_pulse <= '0;
      overrun    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      load_pulse <= '0;
      case (state)
        COLLECT: begin
          if (ena && (|rise)) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (rise[i]) op_reg[i*WIDTH +: WIDTH] <= data_sync[SYNC_STAGES-1];
            end
            op_loaded  <= op_loaded | rise;
            load_pulse <= rise;
          end
          // Uses the registered flags, so the offer starts one edge after the last capture.
          if (&op_loaded) begin
            state     <= OFFER;
            valid_reg <= 1'b1;
          end
        end
        OFFER: begin
          if (ena && (|rise)) overrun <= 1'b1;
          if (bus.out_ready) begin
            state     <= COLLECT;
            valid_reg <= 1'b0;
            op_loaded <= '0;
          end
        end
        default: begin
          state     <= COLLECT;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
`default_nettype none
module tb_operand_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic [3:0] data_in;
  logic [3:0] strobe_in;
  logic [3:0] op_loaded;
  logic [3:0] load_pulse;
  logic       overrun;
  int         total = 0;
  int         bad   = 0;

  operand_loader_if #(.WIDTH(4), .NUM_OPS(4)) bus ();

  operand_loader #(
    .WIDTH(4), .NUM_OPS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .data_in   (data_in),
    .strobe_in (strobe_in),
    .op_loaded (op_loaded),
    .load_pulse(load_pulse),
    .overrun   (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold a strobe mask long enough to capture, then release and let it settle low.
  task automatic press(input logic [3:0] d, input logic [3:0] mask);
    data_in   = d;
    strobe_in = mask;
    tick(6);
    strobe_in = 4'b0000;
    tick(8);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; data_in = 4'h0; strobe_in = 4'h0;
    bus.out_ready = 1'b0;
    tick(3);
    total++;
    if ({bus.op_out, op_loaded, load_pulse, overrun, bus.out_valid} !== 26'd0) begin
      bad++;
      $display("FAIL reset_outputs: got op=%h ld=%b lp=%b ov=%b v=%b want all zero",
               bus.op_out, op_loaded, load_pulse, overrun, bus.out_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [3:0] exp_lp;
    data_in   = 4'h5;
    strobe_in = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      exp_lp = (k == 6) ? 4'b0001 : 4'b0000;
      total++;
      if (load_pulse !== exp_lp) begin
        bad++;
        $display("FAIL latency_edge%0d: load_pulse=%b want %b", k, load_pulse, exp_lp);
      end
    end
    total++;
    if (bus.op_out[3:0] !== 4'h5 || op_loaded !== 4'b0001) begin
      bad++;
      $display("FAIL latency_capture: op0=%h ld=%b want 5 0001", bus.op_out[3:0], op_loaded);
    end
    strobe_in = 4'b0000;
    tick(8);
  endtask

  task automatic test_glitch();
    int pulses;
    data_in   = 4'h7;
    strobe_in = 4'b0010;
    tick(3);
    strobe_in = 4'b0000;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (load_pulse !== 4'b0000) pulses++;
    end
    total++;
    if (pulses != 0 || op_loaded !== 4'b0001) begin
      bad++;
      $display("FAIL glitch_3cyc: pulses=%0d ld=%b want 0 0001", pulses, op_loaded);
    end
    strobe_in = 4'b0010;
    tick(4);
    strobe_in = 4'b0000;
    pulses = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      if (load_pulse === 4'b0010) pulses++;
    end
    total++;
    if (pulses != 1 || op_loaded !== 4'b0011 || bus.op_out[7:4] !== 4'h7) begin
      bad++;
      $display("FAIL glitch_4cyc: pulses=%0d ld=%b op1=%h want 1 0011 7",
               pulses, op_loaded, bus.op_out[7:4]);
    end
    tick(10);
  endtask

  task automatic test_full_set();
    int drops;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++;
    if (op_loaded !== 4'b0000 || bus.op_out !== 16'h0000) begin
      bad++;
      $display("FAIL clear: ld=%b op=%h want 0000 0000", op_loaded, bus.op_out);
    end
    press(4'h1, 4'b0001);
    press(4'h2, 4'b0010);
    press(4'h3, 4'b0100);
    data_in   = 4'h4;
    strobe_in = 4'b1000;
    tick(6);
    total++;
    if (load_pulse !== 4'b1000 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL last_capture: lp=%b v=%b want 1000 0", load_pulse, bus.out_valid);
    end
    tick(1);
    total++;
    if (bus.out_valid !== 1'b1 || bus.op_out !== 16'h4321) begin
      bad++;
      $display("FAIL offer_start: v=%b op=%h want 1 4321", bus.out_valid, bus.op_out);
    end
    strobe_in = 4'b0000;
    drops = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (bus.out_valid !== 1'b1) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++;
      $display("FAIL valid_hold: drops=%0d want 0", drops);
    end
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || op_loaded !== 4'b0000 || bus.op_out !== 16'h4321) begin
      bad++;
      $display("FAIL accept: v=%b ld=%b op=%h want 0 0000 4321",
               bus.out_valid, op_loaded, bus.op_out);
    end
    tick(4);
  endtask

  task automatic test_overrun();
    int pulses;
    press(4'h1, 4'b1111);
    total++;
    if (bus.out_valid !== 1'b1 || bus.op_out !== 16'h1111 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_setup: v=%b op=%h ov=%b want 1 1111 0",
               bus.out_valid, bus.op_out, overrun);
    end
    data_in   = 4'hF;
    strobe_in = 4'b0100;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (load_pulse !== 4'b0000) pulses++;
    end
    strobe_in = 4'b0000;
    total++;
    if (pulses != 0 || bus.op_out !== 16'h1111 || overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_drop: pulses=%0d op=%h ov=%b want 0 1111 1",
               pulses, bus.op_out, overrun);
    end
    tick(8);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    total++;
    if (overrun !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_sticky: ov=%b v=%b want 1 0", overrun, bus.out_valid);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear: ov=%b want 0", overrun);
    end
  endtask

  task automatic test_simul_ena();
    int pulses;
    data_in   = 4'hA;
    strobe_in = 4'b1001;
    tick(6);
    total++;
    if (load_pulse !== 4'b1001 || bus.op_out !== 16'hA00A || op_loaded !== 4'b1001) begin
      bad++;
      $display("FAIL simultaneous: lp=%b op=%h ld=%b want 1001 a00a 1001",
               load_pulse, bus.op_out, op_loaded);
    end
    strobe_in = 4'b0000;
    tick(8);
    ena       = 1'b0;
    data_in   = 4'h5;
    strobe_in = 4'b1001;
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      if (load_pulse !== 4'b0000) pulses++;
    end
    ena = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (load_pulse !== 4'b0000) pulses++;
    end
    total++;
    if (pulses != 0 || bus.op_out !== 16'hA00A || op_loaded !== 4'b1001) begin
      bad++;
      $display("FAIL ena_low: pulses=%0d op=%h ld=%b want 0 a00a 1001",
               pulses, bus.op_out, op_loaded);
    end
    strobe_in = 4'b0000;
    tick(8);
  endtask

  task automatic test_async_reset();
    press(4'h3, 4'b0110);
    total++;
    if (bus.out_valid !== 1'b1 || bus.op_out !== 16'hA33A) begin
      bad++;
      $display("FAIL pre_reset_offer: v=%b op=%h want 1 a33a", bus.out_valid, bus.op_out);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.op_out, op_loaded, load_pulse, overrun, bus.out_valid} !== 26'd0) begin
      bad++;
      $display("FAIL async_reset: op=%h ld=%b lp=%b ov=%b v=%b want all zero",
               bus.op_out, op_loaded, load_pulse, overrun, bus.out_valid);
    end
    tick(2);
    rst_n = 1'b1;
    data_in   = 4'h6;
    strobe_in = 4'b0001;
    tick(6);
    total++;
    if (load_pulse !== 4'b0001 || bus.op_out[3:0] !== 4'h6 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_collect: lp=%b op0=%h v=%b want 0001 6 0",
               load_pulse, bus.op_out[3:0], bus.out_valid);
    end
    strobe_in = 4'b0000;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_full_set();
    test_overrun();
    test_simul_ena();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage of the operand block. Takes raw switch inputs (4-bit data nibble plus four load strobes) and captures operands into four registers, one per strobe.
- Each strobe is synchronised, debounced and edge-detected before it captures anything.
- When all four operands are loaded, the block presents them as one set over a valid/ready handshake to the computing block.

Parameters:
- WIDTH, 4, operand width in bits.
- NUM_OPS, 4, number of operand slots/strobes.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser (min 2).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles before a strobe level change is accepted (min 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- ena  in  1  capture enable; when low, debounced edges are discarded.
- clear  in  1  synchronous clear of all operands and slot flags.
- data_in  in  WIDTH  raw operand nibble from switches.
- strobe_in  in  NUM_OPS  raw per-slot load strobes, active high.
- op_out  out  NUM_OPS*WIDTH  operand registers, slot i at bits [i*WIDTH +: WIDTH].
- op_loaded  out  NUM_OPS  per-slot loaded flag.
- load_pulse  out  NUM_OPS  one-cycle mask of the slots captured this edge.
- out_valid  out  1  complete operand set offered downstream.
- out_ready  in  1  downstream accepts the set.
- overrun  out  1  sticky: a capture was dropped while in OFFER.

Interface (already decided):
- One clock, clk.
- Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (async, rst_n low): all outputs, synchroniser flops, debounce counters and stable levels go to 0. FSM goes to COLLECT. This applies at any time, including mid-debounce and mid-handshake.
- Synchroniser: data_in and strobe_in each pass through SYNC_STAGES flops. All logic below uses the synchronised values only.
- Debounce (per strobe):
  - Counter increments each cycle that sync level != stable level. It resets to 0 on any cycle where they are equal.
  - When the counter is DEBOUNCE_CYCLES-1 and the levels still differ, stable takes the sync level on the next edge and the counter returns to 0.
- Capture event: slot i fires on the edge where its stable level goes 0->1. Falling edges never capture.
- Latency: strobe held high from before edge 1 -> capture on edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
- Glitches: a strobe pulse shorter than DEBOUNCE_CYCLES synchronised cycles produces no capture.
- Capture action, in COLLECT with ena=1:
  - op_out slot i takes the synchronised data on the same edge.
  - op_loaded[i] is set.
  - load_pulse[i]=1 for exactly that cycle.
- Simultaneous captures: all firing slots capture the same data in the same cycle, and load_pulse shows all of their bits.
- Reload: re-capturing an already loaded slot in COLLECT overwrites its value. op_loaded stays 1.
- ena=0: the edge is consumed and not deferred. No register change, no load_pulse. The debounce state still tracks the input.
- FSM states:
  - COLLECT -> OFFER on the edge after op_loaded becomes all-ones. out_valid rises one cycle after the final capture.
  - OFFER: out_valid=1, and op_out and op_loaded are frozen. Any capture event here is dropped, sets overrun, and does not pulse load_pulse.
  - OFFER with out_ready=1 -> COLLECT on that edge. op_loaded is cleared to 0 and op_out is retained.
  - out_valid must not drop until out_ready is seen.
  - out_ready while in COLLECT is ignored.
- clear (synchronous, priority over capture and handshake):
  - op_out=0, op_loaded=0, overrun=0, FSM=COLLECT, out_valid=0 next cycle.
  - Debounce state is unaffected.
- overrun is cleared only by reset or clear.

Decomposition:
- Shared package holds:
  - WIDTH/NUM_OPS defaults.
  - FSM state typedef: COLLECT, OFFER.
  - Slot-index localparams.
- Sub-module strobe_debounce (one instance per strobe) contains:
  - The synchroniser, counter and stable level.
  - A single-cycle rise output.
- The top level holds the operand registers, capture mux, FSM and overrun.

Test Plan:
- Reset/latency: release rst_n; data_in=4'h5, strobe_in=4'b0001 held -> op_out[3:0]=5, load_pulse=0001 exactly on edge 6 only; op_loaded=0001.
- Glitch reject: strobe_in[1] high for 3 cycles, then low -> no load_pulse, op_loaded unchanged. Held 4+ cycles -> capture.
- Full set + handshake: load slots 0..3 with 1,2,3,4 -> out_valid=1 one cycle after the last capture, op_out=16'h4321. Hold out_ready=0 for 5 cycles -> out_valid stays 1. out_ready=1 -> op_loaded=0, out_valid=0 next cycle.
- Overrun: in OFFER, press strobe 2 with data 4'hF -> op_out unchanged, no load_pulse, overrun=1 until clear.
- Simultaneous + ena: strobes 0 and 3 rise together with data 4'hA -> both slots =A, load_pulse=1001. Repeat with ena=0 -> no change.
- Async reset mid-OFFER: assert rst_n low between edges -> all outputs 0 immediately, FSM in COLLECT after release.
